// File: rtl/uart_mem_cmd_bridge.sv
// Byte-stream command engine: parses R/W/B frames from the rx FIFO, issues single-word
// SDRAM requests, and streams read data or acknowledgement bytes back to the tx FIFO.
module uart_mem_cmd_bridge #(
  parameter int DATA_W      = 16,
  parameter int ADR_W       = 24,
  parameter int TIMEOUT_CYC = 1330000
) (
  input  logic              CLK_133MHZ,
  input  logic              rst,
  input  logic [7:0]        i_rx_dat,
  input  logic              i_rx_stb,
  output logic              o_rx_ack,
  output logic [7:0]        o_tx_dat,
  output logic              o_tx_stb,
  input  logic              i_tx_ack,
  output logic              o_req_stb,
  output logic              o_req_we,
  output logic [ADR_W-1:0]  o_req_adr,
  output logic [DATA_W-1:0] o_req_wdata,
  input  logic              i_req_ack,
  input  logic              i_rsp_rd_stb,
  input  logic [DATA_W-1:0] i_rsp_rd_data,
  input  logic              i_rsp_wt_stb,
  output logic              o_rsp_ack,
  output logic [3:0]        o_status,
  output logic [7:0]        o_err_cnt
);
  localparam int DB = DATA_W / 8;
  localparam int AB = (ADR_W + 7) / 8;
  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  localparam logic [3:0] S_IDLE = 4'd0;
  localparam logic [3:0] S_ADDR = 4'd1;
  localparam logic [3:0] S_DATA = 4'd2;
  localparam logic [3:0] S_LEN  = 4'd3;
  localparam logic [3:0] S_REQ  = 4'd4;
  localparam logic [3:0] S_WAIT = 4'd5;
  localparam logic [3:0] S_SEND = 4'd6;
  localparam logic [3:0] S_ACKB = 4'd7;
  localparam logic [3:0] S_ERRB = 4'd8;

  logic [3:0]        r_state;
  logic              r_rx_ack, r_tx_stb, r_req_stb, r_rsp_ack;
  logic [7:0]        r_tx_dat;
  logic              r_we, r_burst;
  logic [ADR_W-1:0]  r_adr;
  logic [DATA_W-1:0] r_wdata, r_rdata;
  logic [3:0]        r_fcnt;
  logic [7:0]        r_len;
  logic [TW-1:0]     r_tmo;
  logic              r_tmo_st, r_bad_st, r_done_tgl;
  logic [7:0]        r_err_cnt;

  logic              w_frame, w_rx_ok, w_rx_xfer, w_tx_xfer, w_req_xfer;
  logic              w_rsp_hit, w_rsp_xfer, w_tmo_hit;
  logic [DATA_W-1:0] w_rdata_nxt;

  assign w_frame     = (r_state == S_ADDR) || (r_state == S_DATA) || (r_state == S_LEN);
  assign w_rx_ok     = w_frame || (r_state == S_IDLE);
  assign w_rx_xfer   = r_rx_ack && i_rx_stb;
  assign w_tx_xfer   = r_tx_stb && i_tx_ack;
  assign w_req_xfer  = r_req_stb && i_req_ack;
  assign w_rsp_hit   = r_we ? i_rsp_wt_stb : i_rsp_rd_stb;
  assign w_rsp_xfer  = r_rsp_ack && w_rsp_hit;
  assign w_tmo_hit   = w_frame && !w_rx_xfer && (r_tmo == TMO_LAST);
  assign w_rdata_nxt = r_rdata << 8;

  assign o_rx_ack    = r_rx_ack;
  assign o_tx_dat    = r_tx_dat;
  assign o_tx_stb    = r_tx_stb;
  assign o_req_stb   = r_req_stb;
  assign o_req_we    = r_we;
  assign o_req_adr   = r_adr;
  assign o_req_wdata = r_wdata;
  assign o_rsp_ack   = r_rsp_ack;
  assign o_status    = {r_done_tgl, r_bad_st, r_tmo_st, (r_state != S_IDLE)};
  assign o_err_cnt   = r_err_cnt;

  always_ff @(posedge CLK_133MHZ or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_rx_ack   <= 1'b0;
      r_tx_stb   <= 1'b0;
      r_tx_dat   <= '0;
      r_req_stb  <= 1'b0;
      r_rsp_ack  <= 1'b0;
      r_we       <= 1'b0;
      r_burst    <= 1'b0;
      r_adr      <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_fcnt     <= '0;
      r_len      <= '0;
      r_tmo      <= '0;
      r_tmo_st   <= 1'b0;
      r_bad_st   <= 1'b0;
      r_done_tgl <= 1'b0;
      r_err_cnt  <= '0;
    end else begin
      // Acks are single-cycle pulses, so at most one byte/response per two cycles.
      r_rx_ack  <= w_rx_ok && i_rx_stb && !r_rx_ack && !w_tmo_hit;
      r_rsp_ack <= (r_state == S_WAIT) && w_rsp_hit && !r_rsp_ack;
      r_tmo     <= (w_frame && !w_rx_xfer) ? r_tmo + TW'(1) : '0;

      case (r_state)
        S_IDLE: if (w_rx_xfer) begin
          r_fcnt <= 4'(AB - 1);
          r_len  <= '0;
          case (i_rx_dat)
            8'h52: begin r_we <= 1'b0; r_burst <= 1'b0; r_state <= S_ADDR; end
            8'h57: begin r_we <= 1'b1; r_burst <= 1'b0; r_state <= S_ADDR; end
            8'h42: begin r_we <= 1'b0; r_burst <= 1'b1; r_state <= S_ADDR; end
            default: begin
              r_bad_st <= 1'b1;
              if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
              r_tx_dat <= 8'h45;
              r_tx_stb <= 1'b1;
              r_state  <= S_ERRB;
            end
          endcase
        end
        S_ADDR: if (w_rx_xfer) begin
          r_adr <= ADR_W'({r_adr, i_rx_dat});
          if (r_fcnt != 4'd0) begin
            r_fcnt <= r_fcnt - 4'd1;
          end else if (r_we) begin
            r_fcnt  <= 4'(DB - 1);
            r_state <= S_DATA;
          end else if (r_burst) begin
            r_state <= S_LEN;
          end else begin
            r_req_stb <= 1'b1;
            r_state   <= S_REQ;
          end
        end
        S_DATA: if (w_rx_xfer) begin
          r_wdata <= DATA_W'({r_wdata, i_rx_dat});
          if (r_fcnt != 4'd0) begin
            r_fcnt <= r_fcnt - 4'd1;
          end else begin
            r_req_stb <= 1'b1;
            r_state   <= S_REQ;
          end
        end
        S_LEN: if (w_rx_xfer) begin
          r_len     <= i_rx_dat;
          r_req_stb <= 1'b1;
          r_state   <= S_REQ;
        end
        S_REQ: if (w_req_xfer) begin
          r_req_stb <= 1'b0;
          r_state   <= S_WAIT;
        end
        S_WAIT: if (w_rsp_xfer) begin
          r_tx_stb <= 1'b1;
          if (r_we) begin
            r_tx_dat <= 8'h4B;
            r_state  <= S_ACKB;
          end else begin
            r_rdata  <= i_rsp_rd_data;
            r_tx_dat <= i_rsp_rd_data[DATA_W-1 -: 8];
            r_fcnt   <= 4'(DB - 1);
            r_state  <= S_SEND;
          end
        end
        S_SEND: if (w_tx_xfer) begin
          if (r_fcnt != 4'd0) begin
            r_rdata  <= w_rdata_nxt;
            r_tx_dat <= w_rdata_nxt[DATA_W-1 -: 8];
            r_fcnt   <= r_fcnt - 4'd1;
          end else begin
            r_tx_stb <= 1'b0;
            if (r_len != 8'd0) begin
              r_adr     <= r_adr + ADR_W'(1);
              r_len     <= r_len - 8'd1;
              r_req_stb <= 1'b1;
              r_state   <= S_REQ;
            end else begin
              r_done_tgl <= ~r_done_tgl;
              r_state    <= S_IDLE;
            end
          end
        end
        S_ACKB: if (w_tx_xfer) begin
          r_tx_stb   <= 1'b0;
          r_done_tgl <= ~r_done_tgl;
          r_state    <= S_IDLE;
        end
        S_ERRB: if (w_tx_xfer) begin
          r_tx_stb <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase

      // A stalled frame is dropped silently; only the sticky flag and counter record it.
      if (w_tmo_hit) begin
        r_tmo_st <= 1'b1;
        if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
        r_state  <= S_IDLE;
      end
    end
  end
endmodule

// File: tb/tb_uart_mem_cmd_bridge.sv
// Scoreboard bench for uart_mem_cmd_bridge: stimulus pushes expected requests/tx bytes,
// monitors pop and compare on each handshake; a TB-owned memory answers requests.
module tb_uart_mem_cmd_bridge;
  localparam int DW  = 16;
  localparam int AW  = 24;
  localparam int TMO = 300;

  logic          CLK_133MHZ = 1'b0;
  logic          rst = 1'b0;
  logic [7:0]    i_rx_dat = '0;
  logic          i_rx_stb = 1'b0;
  logic          o_rx_ack;
  logic [7:0]    o_tx_dat;
  logic          o_tx_stb;
  logic          i_tx_ack = 1'b0;
  logic          o_req_stb, o_req_we;
  logic [AW-1:0] o_req_adr;
  logic [DW-1:0] o_req_wdata;
  logic          i_req_ack = 1'b0;
  logic          i_rsp_rd_stb = 1'b0;
  logic [DW-1:0] i_rsp_rd_data = '0;
  logic          i_rsp_wt_stb = 1'b0;
  logic          o_rsp_ack;
  logic [3:0]    o_status;
  logic [7:0]    o_err_cnt;

  always #4 CLK_133MHZ = ~CLK_133MHZ;

  uart_mem_cmd_bridge #(.DATA_W(DW), .ADR_W(AW), .TIMEOUT_CYC(TMO)) dut (
    .CLK_133MHZ(CLK_133MHZ), .rst(rst),
    .i_rx_dat(i_rx_dat), .i_rx_stb(i_rx_stb), .o_rx_ack(o_rx_ack),
    .o_tx_dat(o_tx_dat), .o_tx_stb(o_tx_stb), .i_tx_ack(i_tx_ack),
    .o_req_stb(o_req_stb), .o_req_we(o_req_we), .o_req_adr(o_req_adr),
    .o_req_wdata(o_req_wdata), .i_req_ack(i_req_ack),
    .i_rsp_rd_stb(i_rsp_rd_stb), .i_rsp_rd_data(i_rsp_rd_data),
    .i_rsp_wt_stb(i_rsp_wt_stb), .o_rsp_ack(o_rsp_ack),
    .o_status(o_status), .o_err_cnt(o_err_cnt));

  typedef struct packed {logic we; logic [AW-1:0] adr; logic [DW-1:0] wd;} req_t;

  req_t       exp_req_q[$];
  logic [7:0] exp_tx_q[$];
  req_t       pend_q[$];
  int         n_cmp = 0, n_bad = 0;
  int         m_err = 0;
  bit         m_tgl = 0, m_bad = 0, m_tmo = 0;
  bit         hold_tx = 0, hold_rsp = 0, abort_rsp = 0, spur_en = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s (wait bound expired) @%0t", nm, $time);
  endtask

  function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
    logic [31:0] h;
    if (a == 24'h000102) return 16'hBEEF;
    h = 32'(a) * 32'h9E3779B1;
    return h[31:16];
  endfunction

  // ---------------- reference model: expected requests and tx bytes ----------------
  task automatic exp_read(input logic [AW-1:0] adr, input int len);
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    for (int i = 0; i <= len; i++) begin
      a = AW'(adr + i);
      exp_req_q.push_back('{we: 1'b0, adr: a, wd: '0});
      d = mem_rd(a);
      for (int b = DW/8 - 1; b >= 0; b--) exp_tx_q.push_back(d[b*8 +: 8]);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int k;
    @(posedge CLK_133MHZ); #1;
    i_rx_dat = b;
    i_rx_stb = 1'b1;
    k = 0;
    do begin @(negedge CLK_133MHZ); k++; end while (!o_rx_ack && k < 2000);
    if (!o_rx_ack) fail_now("rx_ack_wait");
    @(posedge CLK_133MHZ); #1;
    i_rx_stb = 1'b0;
    repeat ($urandom_range(0, 2)) @(posedge CLK_133MHZ);
  endtask

  task automatic send_addr(input logic [AW-1:0] a);
    for (int b = 2; b >= 0; b--) send_byte(a[b*8 +: 8]);
  endtask

  task automatic cmd_read(input logic [AW-1:0] a);
    exp_read(a, 0);
    m_tgl ^= 1'b1;
    send_byte(8'h52);
    send_addr(a);
  endtask

  task automatic cmd_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_req_q.push_back('{we: 1'b1, adr: a, wd: d});
    exp_tx_q.push_back(8'h4B);
    m_tgl ^= 1'b1;
    send_byte(8'h57);
    send_addr(a);
    send_byte(d[15:8]);
    send_byte(d[7:0]);
  endtask

  task automatic cmd_burst(input logic [AW-1:0] a, input logic [7:0] l);
    exp_read(a, int'(l));
    m_tgl ^= 1'b1;
    send_byte(8'h42);
    send_addr(a);
    send_byte(l);
  endtask

  task automatic cmd_bad(input logic [7:0] op);
    exp_tx_q.push_back(8'h45);
    m_bad = 1'b1;
    if (m_err < 255) m_err++;
    send_byte(op);
  endtask

  task automatic wait_idle(input string nm);
    int  k;
    bit  ok;
    k = 0;
    do begin
      @(negedge CLK_133MHZ);
      k++;
      ok = (exp_tx_q.size() == 0) && (exp_req_q.size() == 0) && (o_status[0] == 1'b0);
    end while (!ok && k < 5000);
    if (!ok) fail_now({nm, "_idle"});
    check({nm, "_status"}, o_status, {m_tgl, m_bad, m_tmo, 1'b0});
    check({nm, "_err_cnt"}, o_err_cnt, m_err);
  endtask

  // ---------------- environment drivers (change inputs 1 time unit after posedge) ----------------
  initial forever begin
    @(posedge CLK_133MHZ); #1;
    i_tx_ack  = !hold_tx && ($urandom_range(0, 2) != 0);
    i_req_ack = ($urandom_range(0, 1) != 0);
  end

  initial begin
    req_t p;
    int   k;
    bit   got;
    forever begin
      @(posedge CLK_133MHZ); #1;
      if (pend_q.size() != 0 && !rst) begin
        p = pend_q.pop_front();
        repeat ($urandom_range(0, 4)) begin @(posedge CLK_133MHZ); #1; end
        while (hold_rsp) begin @(posedge CLK_133MHZ); #1; end
        if (abort_rsp) begin
          abort_rsp = 1'b0;
          continue;
        end
        if (!p.we && spur_en) begin
          i_rsp_wt_stb = 1'b1;
          repeat (6) begin
            @(negedge CLK_133MHZ);
            check("spurious_rsp_ack", o_rsp_ack, 64'd0);
          end
          @(posedge CLK_133MHZ); #1;
          i_rsp_wt_stb = 1'b0;
        end
        i_rsp_rd_data = p.we ? '0 : mem_rd(p.adr);
        if (p.we) i_rsp_wt_stb = 1'b1;
        else      i_rsp_rd_stb = 1'b1;
        k = 0;
        do begin @(negedge CLK_133MHZ); got = o_rsp_ack; k++; end while (!got && k < 1000);
        if (!got) fail_now("rsp_ack_wait");
        @(posedge CLK_133MHZ); #1;
        i_rsp_rd_stb = 1'b0;
        i_rsp_wt_stb = 1'b0;
      end
    end
  end

  // ---------------- monitors: sample at negedge, away from the active edge ----------------
  initial begin
    req_t       e;
    logic       prev_stb = 1'b0, prev_xfer = 1'b0;
    logic [7:0] prev_dat = '0;
    forever begin
      @(negedge CLK_133MHZ);
      if (rst) begin
        prev_stb = 1'b0;
      end else begin
        if (prev_stb && !prev_xfer)
          check("tx_hold", {o_tx_stb, o_tx_dat}, {1'b1, prev_dat});
        if (o_tx_stb && i_tx_ack) begin
          if (exp_tx_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL tx_unexpected actual=%0h expected=none @%0t", o_tx_dat, $time);
          end else check("tx_byte", o_tx_dat, exp_tx_q.pop_front());
        end
        if (o_req_stb && i_req_ack) begin
          if (exp_req_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL req_unexpected actual=%0h expected=none @%0t", o_req_adr, $time);
          end else begin
            e = exp_req_q.pop_front();
            check("req_we", o_req_we, e.we);
            check("req_adr", o_req_adr, e.adr);
            if (e.we) check("req_wdata", o_req_wdata, e.wd);
          end
          pend_q.push_back('{we: o_req_we, adr: o_req_adr, wd: o_req_wdata});
        end
        prev_stb  = o_tx_stb;
        prev_dat  = o_tx_dat;
        prev_xfer = o_tx_stb && i_tx_ack;
      end
    end
  end

  initial begin
    #640000;
    $display("FAIL watchdog time limit reached @%0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random stimulus ----------------
  initial begin
    logic [AW-1:0] a, a2;
    logic [7:0]    op, rec;
    int            k;

    #2 rst = 1'b1;
    #1;
    check("rst_ctl", {o_rx_ack, o_tx_stb, o_tx_dat, o_req_stb, o_req_we, o_rsp_ack, o_status, o_err_cnt}, 64'd0);
    check("rst_data", {o_req_adr, o_req_wdata}, 64'd0);
    repeat (3) @(posedge CLK_133MHZ);
    #1 rst = 1'b0;

    cmd_read(24'h000102);
    wait_idle("t1_read");
    cmd_write(24'h000010, 16'h1234);
    wait_idle("t2_write");
    cmd_burst(24'hFFFFFF, 8'h02);
    wait_idle("t3_burst_wrap");

    cmd_bad(8'h58);
    wait_idle("t4_badop");
    send_byte(8'h52);
    send_byte(8'h00);
    repeat (TMO / 2) @(negedge CLK_133MHZ);
    check("t4_busy_before_timeout", o_status[0], 64'd1);
    m_err++;
    m_tmo = 1'b1;
    wait_idle("t4_timeout");

    // tx back-pressure during SEND, with a new frame's opcode pending on rx
    hold_tx = 1'b1;
    cmd_read(24'h00ABCD);
    k = 0;
    do begin @(negedge CLK_133MHZ); k++; end while (!o_tx_stb && k < 2000);
    if (!o_tx_stb) fail_now("t5_tx_stb_wait");
    rec = o_tx_dat;
    a2 = 24'h3C0FF0;
    exp_read(a2, 0);
    m_tgl ^= 1'b1;
    @(posedge CLK_133MHZ); #1;
    i_rx_dat = 8'h52;
    i_rx_stb = 1'b1;
    repeat (100) begin
      @(negedge CLK_133MHZ);
      check("t5_send_stall", {o_rx_ack, o_tx_stb, o_tx_dat}, {1'b0, 1'b1, rec});
    end
    spur_en = 1'b1;
    hold_tx = 1'b0;
    k = 0;
    do begin @(negedge CLK_133MHZ); k++; end while (!o_rx_ack && k < 2000);
    if (!o_rx_ack) fail_now("t5_rx_ack_wait");
    @(posedge CLK_133MHZ); #1;
    i_rx_stb = 1'b0;
    send_addr(a2);
    wait_idle("t5_spurious");
    spur_en = 1'b0;

    for (int i = 0; i < 40; i++) begin
      a = ($urandom_range(0, 3) == 0) ? AW'(24'hFFFFFF - $urandom_range(0, 3)) : AW'($urandom);
      k = $urandom_range(0, 9);
      if (k <= 3)      cmd_read(a);
      else if (k <= 6) cmd_write(a, DW'($urandom));
      else if (k <= 8) cmd_burst(a, 8'($urandom_range(0, 4)));
      else begin
        do op = 8'($urandom); while (op == 8'h52 || op == 8'h57 || op == 8'h42);
        cmd_bad(op);
      end
      if ($urandom_range(0, 1) == 1) wait_idle("rand");
    end
    wait_idle("rand_end");

    for (int i = 0; i < 260; i++) cmd_bad(8'h00);
    wait_idle("err_saturate");

    // reset while a read waits on the memory response
    hold_rsp = 1'b1;
    exp_req_q.push_back('{we: 1'b0, adr: 24'h123456, wd: '0});
    send_byte(8'h52);
    send_addr(24'h123456);
    k = 0;
    do begin @(negedge CLK_133MHZ); k++; end while ((exp_req_q.size() != 0 || pend_q.size() != 0) && k < 2000);
    if (exp_req_q.size() != 0 || pend_q.size() != 0) fail_now("t6_req_wait");
    repeat (3) @(posedge CLK_133MHZ);
    #1;
    check("t6_in_wait_busy", o_status[0], 64'd1);
    rst = 1'b1;
    abort_rsp = 1'b1;
    #1;
    check("t6_rst_ctl", {o_rx_ack, o_tx_stb, o_tx_dat, o_req_stb, o_req_we, o_rsp_ack, o_status, o_err_cnt}, 64'd0);
    check("t6_rst_data", {o_req_adr, o_req_wdata}, 64'd0);
    m_err = 0;
    m_bad = 1'b0;
    m_tmo = 1'b0;
    m_tgl = 1'b0;
    repeat (2) @(posedge CLK_133MHZ);
    #1 rst = 1'b0;
    hold_rsp = 1'b0;
    cmd_read(24'h000102);
    wait_idle("t6_after_reset");

    repeat (5) @(posedge CLK_133MHZ);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
